// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. A request is
//   accepted in IDLE. Its operands go to the ALU for exactly one EXEC cycle.
//   The result is then held in RESP until the owning requester takes it.
//   When both requesters are valid, a one-bit round-robin pointer picks one.
//
// Ports
//   clk, rst                      clock; synchronous active-low reset
//   reqN_valid/ready              request handshake (N = 0, 1)
//   reqN_op, reqN_din1/din2       requested opcode and operands
//   respN_valid/ready             response handshake
//   respN_dout, respN_comp        captured ALU result and comparison flags
//   alu_op, alu_din1/din2         drive to the shared ALU
//   alu_dout, alu_comp            combinational return from the shared ALU
//
// state | meaning
// IDLE  | waiting for a request; grants one combinationally
// EXEC  | latched operation on the ALU; result captured at end of cycle
// RESP  | result presented to owner until respN_ready
module alu_arbiter #(
  parameter int data_width     = 32,
  parameter int alu_op_width   = 32,
  parameter int alu_comp_width = 32,
  parameter logic [alu_op_width-1:0] alu_op_nop = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [alu_op_width-1:0]   req0_op,
  input  logic [data_width-1:0]     req0_din1,
  input  logic [data_width-1:0]     req0_din2,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [alu_op_width-1:0]   req1_op,
  input  logic [data_width-1:0]     req1_din1,
  input  logic [data_width-1:0]     req1_din2,
  output logic                      resp0_valid,
  input  logic                      resp0_ready,
  output logic [data_width-1:0]     resp0_dout,
  output logic [alu_comp_width-1:0] resp0_comp,
  output logic                      resp1_valid,
  input  logic                      resp1_ready,
  output logic [data_width-1:0]     resp1_dout,
  output logic [alu_comp_width-1:0] resp1_comp,
  output logic [alu_op_width-1:0]   alu_op,
  output logic [data_width-1:0]     alu_din1,
  output logic [data_width-1:0]     alu_din2,
  input  logic [data_width-1:0]     alu_dout,
  input  logic [alu_comp_width-1:0] alu_comp
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]                state;
  logic                      ptr;
  logic                      owner;
  logic [alu_op_width-1:0]   op_q;
  logic [data_width-1:0]     din1_q;
  logic [data_width-1:0]     din2_q;
  logic [data_width-1:0]     dout_q;
  logic [alu_comp_width-1:0] comp_q;

  logic grant0;
  logic grant1;
  logic resp_done;

  // A lone requester wins regardless of the pointer. Under contention the
  // pointer side wins. The two grants are mutually exclusive by construction.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !ptr);
    grant1 = req1_valid && (!req0_valid ||  ptr);
  end

  // The reset term keeps the handshakes quiet while rst is low. Without it
  // the outputs could still reflect the pre-reset state in that cycle.
  assign req0_ready  = rst && (state == IDLE) && grant0;
  assign req1_ready  = rst && (state == IDLE) && grant1;
  assign resp0_valid = rst && (state == RESP) && !owner;
  assign resp1_valid = rst && (state == RESP) &&  owner;
  assign resp_done   = owner ? resp1_ready : resp0_ready;

  assign alu_op   = (rst && state == EXEC) ? op_q   : alu_op_nop;
  assign alu_din1 = (rst && state == EXEC) ? din1_q : '0;
  assign alu_din2 = (rst && state == EXEC) ? din2_q : '0;

  assign resp0_dout = dout_q;
  assign resp0_comp = comp_q;
  assign resp1_dout = dout_q;
  assign resp1_comp = comp_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      owner  <= 1'b0;
      op_q   <= '0;
      din1_q <= '0;
      din2_q <= '0;
      dout_q <= '0;
      comp_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner  <= grant1;
            ptr    <= grant0;   // point at the side that lost
            op_q   <= grant1 ? req1_op   : req0_op;
            din1_q <= grant1 ? req1_din1 : req0_din1;
            din2_q <= grant1 ? req1_din2 : req0_din2;
            state  <= EXEC;
          end
        end
        EXEC: begin
          dout_q <= alu_dout;
          comp_q <= alu_comp;
          state  <= RESP;
        end
        RESP: begin
          if (resp_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam logic [31:0] NOP  = 32'd0;
  localparam logic [31:0] ADD  = 32'd1;
  localparam logic [31:0] SUB  = 32'd2;
  localparam logic [31:0] SLT  = 32'd3;
  localparam logic [31:0] SLTU = 32'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_op, req0_din1, req0_din2, req1_op, req1_din1, req1_din2;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp0_dout, resp1_dout, resp0_comp, resp1_comp;
  logic [31:0] alu_op, alu_din1, alu_din2, alu_dout, alu_comp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stand-in for the external ALU. Flag bits: 0 = eq, 1 = signed lt, 2 = unsigned lt.
  always_comb begin
    alu_comp = {29'd0, (alu_din1 < alu_din2),
                ($signed(alu_din1) < $signed(alu_din2)), (alu_din1 == alu_din2)};
    case (alu_op)
      ADD:     alu_dout = alu_din1 + alu_din2;
      SUB:     alu_dout = alu_din1 - alu_din2;
      SLT:     alu_dout = {31'd0, $signed(alu_din1) < $signed(alu_din2)};
      SLTU:    alu_dout = {31'd0, alu_din1 < alu_din2};
      default: alu_dout = 32'd0;
    endcase
  end

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_din1(req0_din1), .req0_din2(req0_din2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_din1(req1_din1), .req1_din2(req1_din2),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_dout(resp0_dout), .resp0_comp(resp0_comp),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_dout(resp1_dout), .resp1_comp(resp1_comp),
    .alu_op(alu_op), .alu_din1(alu_din1), .alu_din2(alu_din2),
    .alu_dout(alu_dout), .alu_comp(alu_comp)
  );

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    next_cycle(); settle();
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_req0_ready: got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_req1_ready: got %b want 0", req1_ready); end
    checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b%b want 00", resp1_valid, resp0_valid); end
    checks++; if (alu_op !== NOP) begin errors++; $display("FAIL rst_alu_op: got %0h want %0h", alu_op, NOP); end
    checks++; if (resp0_dout !== 32'd0) begin errors++; $display("FAIL rst_dout: got %0h want 0", resp0_dout); end
    next_cycle();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    next_cycle();
    req0_valid = 1'b1; req0_op = ADD; req0_din1 = 32'd5; req0_din2 = 32'd7; resp0_ready = 1'b1;
    settle();
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_grant: got %b%b want 01", req1_ready, req0_ready); end
    checks++; if (alu_op !== NOP) begin errors++; $display("FAIL single_idle_op: got %0h want %0h", alu_op, NOP); end
    next_cycle(); req0_valid = 1'b0; settle();
    checks++; if (alu_op !== ADD || alu_din1 !== 32'd5 || alu_din2 !== 32'd7) begin errors++; $display("FAIL single_exec: got op=%0h a=%0d b=%0d want op=%0h a=5 b=7", alu_op, alu_din1, alu_din2, ADD); end
    checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", resp0_valid); end
    next_cycle(); settle();
    checks++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0) begin errors++; $display("FAIL single_resp_valid: got %b%b want 01", resp1_valid, resp0_valid); end
    checks++; if (resp0_dout !== 32'd12) begin errors++; $display("FAIL single_dout: got %0d want 12", resp0_dout); end
    checks++; if (alu_op !== NOP || alu_din1 !== 32'd0) begin errors++; $display("FAIL single_resp_alu: got op=%0h a=%0h want nop/0", alu_op, alu_din1); end
    next_cycle(); req0_valid = 1'b1; req0_op = ADD; settle();
    checks++; if (resp0_valid !== 1'b0 || resp0_dout !== 32'd12) begin errors++; $display("FAIL single_hold: got v=%b dout=%0d want v=0 dout=12", resp0_valid, resp0_dout); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_back_idle: got %b want 1", req0_ready); end
    req0_valid = 1'b0;
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1'b1; req0_op = SUB;  req0_din1 = 32'd10; req0_din2 = 32'd3;
    req1_valid = 1'b1; req1_op = SLTU; req1_din1 = 32'd1;  req1_din2 = 32'd2;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    settle();
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL cont_first: got %b%b want 01", req1_ready, req0_ready); end
    next_cycle(); settle();
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL cont_exec_ready: got %b%b want 00", req1_ready, req0_ready); end
    next_cycle(); settle();
    checks++; if (resp0_valid !== 1'b1 || resp0_dout !== 32'd7) begin errors++; $display("FAIL cont_resp0: got v=%b dout=%0d want v=1 dout=7", resp0_valid, resp0_dout); end
    next_cycle(); settle();
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL cont_second: got %b%b want 10", req1_ready, req0_ready); end
    next_cycle(); next_cycle(); settle();
    checks++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp1_dout !== 32'd1) begin errors++; $display("FAIL cont_resp1: got v=%b%b dout=%0d want v=10 dout=1", resp1_valid, resp0_valid, resp1_dout); end
    checks++; if (resp1_comp !== 32'h6) begin errors++; $display("FAIL cont_comp1: got %0h want 6", resp1_comp); end
    next_cycle(); settle();
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL cont_third: got %b%b want 01", req1_ready, req0_ready); end
    next_cycle(); req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle(); settle();
    checks++; if (resp0_valid !== 1'b1 || resp0_dout !== 32'd7) begin errors++; $display("FAIL cont_resp0b: got v=%b dout=%0d want v=1 dout=7", resp0_valid, resp0_dout); end
    next_cycle();
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic test_resp_stall();
    req1_valid = 1'b1; req1_op = ADD; req1_din1 = 32'd100; req1_din2 = 32'd23; resp1_ready = 1'b0;
    settle();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL stall_grant1: got %b want 1", req1_ready); end
    next_cycle();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_op = ADD; req0_din1 = 32'd1; req0_din2 = 32'd1;
    resp0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); settle();
      checks++; if (resp1_valid !== 1'b1 || resp1_dout !== 32'd123) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b dout=%0d want v=1 dout=123", i, resp1_valid, resp1_dout); end
      checks++; if (req0_ready !== 1'b0 || resp0_valid !== 1'b0) begin errors++; $display("FAIL stall_block[%0d]: got ready=%b v0=%b want 0 0", i, req0_ready, resp0_valid); end
    end
    next_cycle(); resp1_ready = 1'b1; settle();
    checks++; if (resp1_valid !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL stall_handshake: got v1=%b ready0=%b want 1 0", resp1_valid, req0_ready); end
    next_cycle(); resp1_ready = 1'b0; settle();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL stall_after: got %b want 1", req0_ready); end
    next_cycle(); req0_valid = 1'b0;
    next_cycle(); settle();
    checks++; if (resp0_valid !== 1'b1 || resp0_dout !== 32'd2) begin errors++; $display("FAIL stall_resp0: got v=%b dout=%0d want v=1 dout=2", resp0_valid, resp0_dout); end
    next_cycle();
  endtask

  task automatic test_operand_latch();
    req0_valid = 1'b1; req0_op = SLT; req0_din1 = 32'hFFFF_FFFF; req0_din2 = 32'd1; resp0_ready = 1'b1;
    settle();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL latch_grant: got %b want 1", req0_ready); end
    next_cycle(); req0_valid = 1'b0; req0_din1 = 32'd5; req0_op = ADD; settle();
    checks++; if (alu_op !== SLT || alu_din1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL latch_exec: got op=%0h a=%0h want op=%0h a=ffffffff", alu_op, alu_din1, SLT); end
    next_cycle(); settle();
    checks++; if (resp0_dout !== 32'd1) begin errors++; $display("FAIL latch_dout: got %0d want 1", resp0_dout); end
    checks++; if (resp0_comp !== 32'h2) begin errors++; $display("FAIL latch_comp: got %0h want 2", resp0_comp); end
    next_cycle();
  endtask

  task automatic test_reset_in_flight();
    req0_valid = 1'b1; req0_op = ADD; req0_din1 = 32'd3; req0_din2 = 32'd4; resp0_ready = 1'b1;
    settle();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rif_grant: got %b want 1", req0_ready); end
    next_cycle(); req0_valid = 1'b0; rst = 1'b0; settle();
    checks++; if (alu_op !== NOP) begin errors++; $display("FAIL rif_op_in_rst: got %0h want %0h", alu_op, NOP); end
    next_cycle(); rst = 1'b1; settle();
    checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin errors++; $display("FAIL rif_no_resp: got %b%b want 00", resp1_valid, resp0_valid); end
    checks++; if (resp0_dout !== 32'd0 || alu_op !== NOP || alu_din1 !== 32'd0) begin errors++; $display("FAIL rif_cleared: got dout=%0h op=%0h a=%0h want 0/nop/0", resp0_dout, alu_op, alu_din1); end
    next_cycle();
    req0_valid = 1'b1; req1_valid = 1'b1; req1_op = ADD; resp1_ready = 1'b1;
    settle();
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rif_ptr_zero: got %b%b want 01", req1_ready, req0_ready); end
    next_cycle(); req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle(); next_cycle();
    resp1_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    req0_valid = 1'b1; req0_op = ADD; req0_din1 = 32'd2; req0_din2 = 32'd3; resp0_ready = 1'b1;
    settle();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b want 1", req0_ready); end
    next_cycle(); settle();
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL b2b_exec: got %b want 0", req0_ready); end
    next_cycle(); settle();
    checks++; if (resp0_valid !== 1'b1 || resp0_dout !== 32'd5) begin errors++; $display("FAIL b2b_resp: got v=%b dout=%0d want v=1 dout=5", resp0_valid, resp0_dout); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_accept: got %b want 0", req0_ready); end
    next_cycle(); req0_din1 = 32'd4; req0_din2 = 32'd4; settle();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_reaccept: got %b want 1", req0_ready); end
    next_cycle(); req0_valid = 1'b0;
    next_cycle(); settle();
    checks++; if (resp0_valid !== 1'b1 || resp0_dout !== 32'd8) begin errors++; $display("FAIL b2b_second: got v=%b dout=%0d want v=1 dout=8", resp0_valid, resp0_dout); end
    next_cycle();
    resp0_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req0_op = NOP; req0_din1 = '0; req0_din2 = '0;
    req1_valid = 1'b0; req1_op = NOP; req1_din1 = '0; req1_din2 = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_resp_stall();
    test_operand_latch();
    test_reset_in_flight();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
